// File: rtl/tensor_array_ctrl_if.sv
// Handshake bundle between the tensor array sequencer and its neighbours:
// operand fetch (start/k_steps/op_valid/op_take), the PE array controls
// (feed_valid/pe_reset/load_sum) and the result drain port.
interface tensor_array_ctrl_if #(
  parameter int M_ROWS = 4,
  parameter int K_W    = 16
);
  localparam int ROW_W = (M_ROWS > 1) ? $clog2(M_ROWS) : 1;

  logic             start;
  logic [K_W-1:0]   k_steps;
  logic             op_valid;
  logic             op_take;
  logic             feed_valid;
  logic             pe_reset;
  logic             load_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_row;
  logic             busy;
  logic             done;

  // Sequencer side
  modport master (
    input  start, k_steps, op_valid, out_ready,
    output op_take, feed_valid, pe_reset, load_sum, out_valid, out_row, busy, done
  );

  // Fetch / array / consumer side
  modport slave (
    output start, k_steps, op_valid, out_ready,
    input  op_take, feed_valid, pe_reset, load_sum, out_valid, out_row, busy, done
  );
endinterface

// File: rtl/tensor_array_ctrl.sv
// Sequencer for the M_ROWS x N_COLS tensor PE systolic array: clears the
// accumulators, meters k_steps operand beats into the skew buffers, waits for
// the wavefront to flush, then drains result rows out of the array bottom.
// Optional feature macro: TENSOR_CTRL_PERF_EN adds saturating perf counters.
module tensor_array_ctrl #(
  parameter int M_ROWS   = 4,
  parameter int N_COLS   = 4,
  parameter int K_W      = 16,
  parameter int SKEW_LAT = 0
) (
  input  logic clk,
  input  logic reset,
`ifdef TENSOR_CTRL_PERF_EN
  output logic [31:0] perf_busy_cyc,
  output logic [31:0] perf_feed_stall,
  output logic [31:0] perf_drain_stall,
`endif
  tensor_array_ctrl_if.master bus
);

  localparam int FLUSH_CYC = M_ROWS + N_COLS - 2 + SKEW_LAT;
  // A degenerate 1x1 array with no skew still spends one cycle in FLUSH.
  localparam int FLUSH_N   = (FLUSH_CYC > 0) ? FLUSH_CYC : 1;
  localparam int FL_W      = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;
  localparam int ROW_W     = (M_ROWS > 1) ? $clog2(M_ROWS) : 1;

  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(FLUSH_N - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(M_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [K_W-1:0]   k_lat;
  logic [K_W-1:0]   beat_cnt;
  logic [FL_W-1:0]  flush_cnt;
  logic [ROW_W-1:0] drain_cnt;
  logic             take;
  logic             xfer;
  logic             accept;

  assign accept = (state == S_IDLE) && bus.start;

  // Next-state decode plus the handshake-dependent strobes
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    xfer      = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = (k_lat == '0) ? S_FLUSH : S_FEED;
      S_FEED: begin
        take = bus.op_valid;
        if (take && (beat_cnt + K_W'(1) == k_lat)) state_nxt = S_FLUSH;
      end
      S_FLUSH: if (flush_cnt == FLUSH_LAST) state_nxt = S_DRAIN;
      S_DRAIN: begin
        xfer = bus.out_ready;
        if (xfer && (drain_cnt == ROW_LAST)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Tile length capture and beat/flush/drain counters, rearmed on accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      k_lat     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      drain_cnt <= '0;
    end else if (accept) begin
      k_lat     <= bus.k_steps;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      if (take)               beat_cnt  <= beat_cnt + K_W'(1);
      if (state == S_FLUSH)   flush_cnt <= flush_cnt + FL_W'(1);
      if (xfer)               drain_cnt <= drain_cnt + ROW_W'(1);
    end
  end

  assign bus.op_take    = take;
  assign bus.feed_valid = take;
  assign bus.pe_reset   = reset || (state == S_CLEAR);
  assign bus.load_sum   = xfer;
  assign bus.out_valid  = (state == S_DRAIN);
  assign bus.out_row    = ROW_LAST - drain_cnt;
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);

`ifdef TENSOR_CTRL_PERF_EN
  // Saturating tile statistics; held after DONE until the next accepted start
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      perf_busy_cyc    <= '0;
      perf_feed_stall  <= '0;
      perf_drain_stall <= '0;
    end else begin
      if ((state != S_IDLE) && (perf_busy_cyc != '1))
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if ((state == S_FEED) && !bus.op_valid && (perf_feed_stall != '1))
        perf_feed_stall <= perf_feed_stall + 32'd1;
      if ((state == S_DRAIN) && !bus.out_ready && (perf_drain_stall != '1))
        perf_drain_stall <= perf_drain_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tensor_array_ctrl.sv
// Scoreboard bench for tensor_array_ctrl: an idealised (skew-free) PE array
// model is driven by the DUT controls, and its bottom row is compared against
// golden A*B rows queued by the stimulus process.
module tb_tensor_array_ctrl;
  localparam int M    = 4;
  localparam int N    = 4;
  localparam int KW   = 16;
  localparam int F    = M + N - 2;
  localparam int KMAX = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tensor_array_ctrl_if #(.M_ROWS(M), .K_W(KW)) bus ();

`ifdef TENSOR_CTRL_PERF_EN
  logic [31:0] perf_busy_cyc, perf_feed_stall, perf_drain_stall;
`endif

  tensor_array_ctrl #(.M_ROWS(M), .N_COLS(N), .K_W(KW), .SKEW_LAT(0)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef TENSOR_CTRL_PERF_EN
    .perf_busy_cyc    (perf_busy_cyc),
    .perf_feed_stall  (perf_feed_stall),
    .perf_drain_stall (perf_drain_stall),
`endif
    .bus   (bus)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int clear_cyc = -1;
  int beat_idx = 0;
  bit chk_idle_next = 0;

  int a_mem [KMAX][M][4];
  int b_mem [KMAX][4][N];
  int acc   [M][N];

  int exp_take_q[$];
  int exp_xfer_q[$];
  int exp_row_q[$];
  int exp_val_q[$];
  int exp_done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Monitor: compare DUT events against queued expectations, then advance the array model
  always @(negedge clk) begin
    check("pe_reset", bus.pe_reset, (reset || cyc == clear_cyc) ? 1 : 0);
    if (chk_idle_next) begin
      check("busy_after_done", bus.busy, 0);
      chk_idle_next = 0;
    end
    if (bus.op_take) begin
      if (exp_take_q.size() == 0) check("take_extra", cyc, -1);
      else check("take_cycle", cyc, exp_take_q.pop_front());
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_xfer_q.size() == 0) check("xfer_extra", cyc, -1);
      else begin
        check("xfer_cycle", cyc, exp_xfer_q.pop_front());
        check("out_row", bus.out_row, exp_row_q.pop_front());
        for (int j = 0; j < N; j++) check("row_data", acc[M-1][j], exp_val_q.pop_front());
      end
    end
    if (bus.done) begin
      if (exp_done_q.size() == 0) check("done_extra", cyc, -1);
      else check("done_cycle", cyc, exp_done_q.pop_front());
      chk_idle_next = 1;
    end
    if (bus.pe_reset) begin
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) acc[i][j] = 0;
    end else if (bus.load_sum) begin
      for (int j = 0; j < N; j++) begin
        for (int i = M-1; i > 0; i--) acc[i][j] = acc[i-1][j];
        acc[0][j] = 0;
      end
    end else if (bus.feed_valid && beat_idx < KMAX) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          for (int t = 0; t < 4; t++)
            acc[i][j] += a_mem[beat_idx][i][t] * b_mem[beat_idx][t][j];
    end
    if (bus.op_take) beat_idx++;
  end

  task automatic flush_queues();
    exp_take_q.delete(); exp_xfer_q.delete(); exp_row_q.delete();
    exp_val_q.delete();  exp_done_q.delete();
  endtask

  // One tile: gap_pct = op_valid bubble probability, stall_row/stall_len = out_ready
  // hold-off before that drain row, start_drain pulses start mid-drain,
  // abort_at >= 0 asserts reset at that cycle offset.
  task automatic run_tile(input int k, input int gap_pct, input int stall_row,
                          input int stall_len, input bit start_drain, input int abort_at);
    int c[M][N];
    int feed_pat[$];
    int drain_pat[$];
    int s, L, D, endo, r;
    for (int b = 0; b < k; b++) begin
      for (int i = 0; i < M; i++) for (int t = 0; t < 4; t++)
        a_mem[b][i][t] = int'($urandom_range(255)) - 128;
      for (int t = 0; t < 4; t++) for (int j = 0; j < N; j++)
        b_mem[b][t][j] = int'($urandom_range(255)) - 128;
    end
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) begin
      c[i][j] = 0;
      for (int b = 0; b < k; b++) for (int t = 0; t < 4; t++)
        c[i][j] += a_mem[b][i][t] * b_mem[b][t][j];
    end
    for (int b = 0; b < k; b++) begin
      if (int'($urandom_range(99)) < gap_pct)
        for (int g = 0; g < int'($urandom_range(2, 1)); g++) feed_pat.push_back(0);
      feed_pat.push_back(1);
    end
    for (int rr = 0; rr < M; rr++) begin
      if (rr == stall_row) for (int g = 0; g < stall_len; g++) drain_pat.push_back(0);
      drain_pat.push_back(1);
    end
    L = feed_pat.size();
    D = drain_pat.size();
    endo = 2 + L + F + D;
    s = cyc;
    clear_cyc = s + 1;
    for (int i = 0; i < L; i++) if (feed_pat[i] == 1) exp_take_q.push_back(s + 2 + i);
    r = 0;
    for (int i = 0; i < D; i++) if (drain_pat[i] == 1) begin
      exp_xfer_q.push_back(s + 2 + L + F + i);
      exp_row_q.push_back(M - 1 - r);
      for (int j = 0; j < N; j++) exp_val_q.push_back(c[M-1-r][j]);
      r++;
    end
    exp_done_q.push_back(s + endo);
    beat_idx = 0;
    for (int o = 0; o <= endo; o++) begin
      bus.start     = (o == 0) || (start_drain && o == 3 + L + F);
      bus.k_steps   = (o == 0) ? KW'(k) : KW'($urandom);
      bus.op_valid  = (o >= 2 && o < 2 + L) ? feed_pat[o-2][0] : 1'($urandom_range(1));
      bus.out_ready = (o >= 2 + L + F && o < endo) ? drain_pat[o-2-L-F][0] : 1'($urandom_range(1));
      if (o == abort_at) begin
        reset = 1'b1;
        bus.op_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (o == abort_at) begin
        reset = 1'b0;
        flush_queues();
        clear_cyc = -1;
        check("abort_idle", bus.busy, 0);
        bus.start = 1'b0;
        return;
      end
    end
    bus.start = 1'b0;
    for (int w = 0; w < 40 && exp_done_q.size() > 0; w++) begin
      @(posedge clk); #1;
    end
    check("done_pending", exp_done_q.size(), 0);
    check("takes_left", exp_take_q.size(), 0);
    check("rows_left", exp_row_q.size(), 0);
`ifdef TENSOR_CTRL_PERF_EN
    check("perf_busy_cyc", perf_busy_cyc, endo);
    check("perf_feed_stall", perf_feed_stall, L - k);
    check("perf_drain_stall", perf_drain_stall, D - M);
`endif
    flush_queues();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.k_steps = '0; bus.op_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.op_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_op_take", bus.op_take, 0);
    check("rst_load_sum", bus.load_sum, 0);
    check("rst_pe_reset", bus.pe_reset, 0);
    @(posedge clk); #1;

    run_tile(3, 0, -1, 0, 0, -1);
    run_tile(0, 0, -1, 0, 0, -1);
    run_tile(8, 30, -1, 0, 0, -1);
    run_tile(5, 0, 2, 5, 0, -1);
    run_tile(6, 20, -1, 0, 0, 4);
    run_tile(4, 0, -1, 0, 0, -1);
    run_tile(4, 0, -1, 0, 1, -1);
    for (int n = 0; n < 6; n++)
      run_tile(int'($urandom_range(12)), 30, int'($urandom_range(M-1)),
               int'($urandom_range(4)), 1'($urandom_range(1)), -1);
    run_tile(2, 0, -1, 0, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", bus.busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=%0d required=%0d", cyc, 0);
    $fatal(1, "bench timeout");
  end
endmodule
